// File: rtl/parking_pkg.sv
// Shared defaults, gate state encoding and count type for the parking occupancy counter.
package parking_pkg;

    localparam int unsigned CAPACITY_DEF = 8;
    localparam int unsigned WIDTH_DEF    = 4;
    localparam int unsigned TIMEOUT_DEF  = 16;
    localparam int unsigned DEBOUNCE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        PASSING = 2'd2
    } gate_state_e;

    typedef logic [WIDTH_DEF-1:0] count_t;

endpackage

// File: rtl/parking_occupancy_counter_gate_fsm.sv
// One barrier gate: open on permitted request, close after a full beam pass or a timeout.
// Optional beam stability filter enabled by SENSOR_DEBOUNCE_EN.
module gate_fsm
    import parking_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
`ifdef SENSOR_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic request,
    input  logic beam,
    input  logic permit,
    output logic gate,
    output logic done,
    output logic denied
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    gate_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          beam_q;
    logic          beam_s;
    logic          beam_prev_q;
    logic          req_prev_q;
    logic          gate_q, gate_d;
    logic          denied_q, denied_d;

`ifdef SENSOR_DEBOUNCE_EN
    localparam int unsigned DW = $clog2(DEBOUNCE + 1);

    logic [DW-1:0] stab_q, stab_d;
    logic          filt_q, filt_d;

    // Filtered beam follows the raw sample only after DEBOUNCE consecutive differing samples.
    always_comb begin
        stab_d = '0;
        filt_d = filt_q;
        if (beam_q != filt_q) begin
            if (stab_q == DW'(DEBOUNCE - 1)) begin
                filt_d = beam_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stab_q <= '0;
            filt_q <= 1'b0;
        end else begin
            stab_q <= stab_d;
            filt_q <= filt_d;
        end
    end

    assign beam_s = filt_q;
`else
    assign beam_s = beam_q;
`endif

    // Next state; done is combinational so the counter sees it on the following edge.
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (request && permit) state_d = OPEN;
            end
            OPEN: begin
                if (beam_s) begin
                    state_d = PASSING;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            PASSING: begin
                if (beam_prev_q && !beam_s) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        gate_d   = (state_d != IDLE);
        denied_d = (state_q == IDLE) && request && !req_prev_q && !permit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            beam_q      <= 1'b0;
            beam_prev_q <= 1'b0;
            req_prev_q  <= 1'b0;
            gate_q      <= 1'b0;
            denied_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            beam_q      <= beam;
            beam_prev_q <= beam_s;
            req_prev_q  <= request;
            gate_q      <= gate_d;
            denied_q    <= denied_d;
        end
    end

    assign gate   = gate_q;
    assign denied = denied_q;

endmodule

// File: rtl/parking_occupancy_counter.sv
// Parking lot occupancy: two gate FSMs feeding a saturating up/down car counter.
// Build option SENSOR_DEBOUNCE_EN adds a beam stability filter inside each gate.
module parking_occupancy_counter
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY = CAPACITY_DEF,
    parameter int unsigned WIDTH    = WIDTH_DEF,
`ifdef SENSOR_DEBOUNCE_EN
    parameter int unsigned DEBOUNCE = DEBOUNCE_DEF,
`endif
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_request,
    input  logic             entry_beam,
    input  logic             exit_request,
    input  logic             exit_beam,
    output logic             entry_gate,
    output logic             exit_gate,
    output logic             entry_denied,
    output logic [WIDTH-1:0] parked,
    output logic             full,
    output logic             lot_empty
);

    logic [WIDTH-1:0] parked_q, parked_d;
    logic             full_q, empty_q;
    logic             entry_permit, exit_permit;
    logic             entry_done, exit_done;
    logic             exit_denied_unused;

    assign entry_permit = (parked_q != WIDTH'(CAPACITY));
    assign exit_permit  = (parked_q != '0);

    gate_fsm #(
        .TIMEOUT (TIMEOUT)
`ifdef SENSOR_DEBOUNCE_EN
        , .DEBOUNCE(DEBOUNCE)
`endif
    ) u_entry (
        .clk    (clk),
        .reset  (reset),
        .request(entry_request),
        .beam   (entry_beam),
        .permit (entry_permit),
        .gate   (entry_gate),
        .done   (entry_done),
        .denied (entry_denied)
    );

    gate_fsm #(
        .TIMEOUT (TIMEOUT)
`ifdef SENSOR_DEBOUNCE_EN
        , .DEBOUNCE(DEBOUNCE)
`endif
    ) u_exit (
        .clk    (clk),
        .reset  (reset),
        .request(exit_request),
        .beam   (exit_beam),
        .permit (exit_permit),
        .gate   (exit_gate),
        .done   (exit_done),
        .denied (exit_denied_unused)
    );

    // Simultaneous entry and exit cancel; saturate at both ends.
    always_comb begin
        parked_d = parked_q;
        case ({entry_done, exit_done})
            2'b10: if (parked_q != WIDTH'(CAPACITY)) parked_d = parked_q + 1'b1;
            2'b01: if (parked_q != '0) parked_d = parked_q - 1'b1;
            default: parked_d = parked_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parked_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            parked_q <= parked_d;
            full_q   <= (parked_d == WIDTH'(CAPACITY));
            empty_q  <= (parked_d == '0);
        end
    end

    assign parked    = parked_q;
    assign full      = full_q;
    assign lot_empty = empty_q;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Self-checking bench for parking_occupancy_counter: scripted table, corner sequences, random traffic.
module tb_parking_occupancy_counter;
    import parking_pkg::*;

`ifdef SENSOR_DEBOUNCE_EN
    localparam int LAT  = DEBOUNCE_DEF;
    localparam int HMIN = DEBOUNCE_DEF;
`else
    localparam int LAT  = 0;
    localparam int HMIN = 1;
`endif
    localparam int CAP = CAPACITY_DEF;

    typedef struct {
        bit ent;
        bit ext;
        bit eg;
        bit xg;
        bit den;
        int parked;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       entry_request = 1'b0;
    logic       entry_beam = 1'b0;
    logic       exit_request = 1'b0;
    logic       exit_beam = 1'b0;
    logic       entry_gate, exit_gate, entry_denied, full, lot_empty;
    logic [3:0] parked;

    int checks = 0;
    int errors = 0;
    int model_parked = 0;

    always #5 clk = ~clk;

    parking_occupancy_counter dut (
        .clk          (clk),
        .reset        (reset),
        .entry_request(entry_request),
        .entry_beam   (entry_beam),
        .exit_request (exit_request),
        .exit_beam    (exit_beam),
        .entry_gate   (entry_gate),
        .exit_gate    (exit_gate),
        .entry_denied (entry_denied),
        .parked       (parked),
        .full         (full),
        .lot_empty    (lot_empty)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit e, input bit x, input bit eg, input bit xg,
                                input bit den, input int p);
        vec_t v;
        v.ent = e; v.ext = x; v.eg = eg; v.xg = xg; v.den = den; v.parked = p;
        return v;
    endfunction

    // One transaction: request, beam pass of 'hold' cycles on opened gates, check count latency.
    task automatic run_step(input vec_t v, input int hold, input string tag);
        entry_request = v.ent;
        exit_request  = v.ext;
        @(negedge clk);
        chk($sformatf("%s entry_gate_open", tag), int'(entry_gate), int'(v.eg));
        chk($sformatf("%s exit_gate_open", tag), int'(exit_gate), int'(v.xg));
        chk($sformatf("%s entry_denied", tag), int'(entry_denied), int'(v.den));
        entry_request = 1'b0;
        exit_request  = 1'b0;
        entry_beam    = v.eg;
        exit_beam     = v.xg;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 0) chk($sformatf("%s denied_one_cycle", tag), int'(entry_denied), 0);
        end
        entry_beam = 1'b0;
        exit_beam  = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        chk($sformatf("%s entry_gate_until_fall", tag), int'(entry_gate), int'(v.eg));
        chk($sformatf("%s parked_before", tag), int'(parked), model_parked);
        @(negedge clk);
        chk($sformatf("%s entry_gate_closed", tag), int'(entry_gate), 0);
        chk($sformatf("%s exit_gate_closed", tag), int'(exit_gate), 0);
        chk($sformatf("%s parked", tag), int'(parked), v.parked);
        chk($sformatf("%s full", tag), int'(full), int'(v.parked == CAP));
        chk($sformatf("%s lot_empty", tag), int'(lot_empty), int'(v.parked == 0));
        model_parked = v.parked;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl [16];
        vec_t v;
        int   hi;
        int   cnt;
        bit   e, x;

        tbl[0] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 8; i++) tbl[i] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, i);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6);
        tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5);
        tbl[13] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5);
        tbl[14] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5);
        tbl[15] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset parked", int'(parked), 0);
        chk("reset lot_empty", int'(lot_empty), 1);
        chk("reset full", int'(full), 0);
        chk("reset entry_gate", int'(entry_gate), 0);
        chk("reset exit_gate", int'(exit_gate), 0);
        chk("reset entry_denied", int'(entry_denied), 0);
        reset = 1'b0;
        @(negedge clk);

        // Timeout: no beam, request dropped while open
        entry_request = 1'b1;
        @(negedge clk);
        chk("timeout gate_opens", int'(entry_gate), 1);
        entry_request = 1'b0;
        hi = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (entry_gate) hi++;
            else break;
        end
        chk("timeout open_cycles", hi, 16);
        chk("timeout parked", int'(parked), 0);

        // Beam while idle without a request
        entry_beam = 1'b1;
        repeat (HMIN + 2) @(negedge clk);
        entry_beam = 1'b0;
        repeat (LAT + 5) @(negedge clk);
        chk("idle_beam parked", int'(parked), 0);
        chk("idle_beam gate", int'(entry_gate), 0);

        for (int i = 0; i < 16; i++) run_step(tbl[i], HMIN + 2, $sformatf("tbl%0d", i));

        // Reset in the middle of a pass
        entry_request = 1'b1;
        @(negedge clk);
        entry_request = 1'b0;
        entry_beam    = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        chk("midreset gate_before", int'(entry_gate), 1);
        reset = 1'b1;
        #1;
        chk("midreset parked", int'(parked), 0);
        chk("midreset lot_empty", int'(lot_empty), 1);
        chk("midreset entry_gate", int'(entry_gate), 0);
        chk("midreset full", int'(full), 0);
        @(negedge clk);
        reset      = 1'b0;
        entry_beam = 1'b0;
        repeat (LAT + 5) @(negedge clk);
        chk("midreset lost_pass", int'(parked), 0);
        model_parked = 0;

        // Random traffic against an arithmetic occupancy model
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            e = ($urandom % 100) < ((k < 30) ? 75 : 25);
            x = ($urandom % 100) < ((k < 30) ? 30 : 75);
            if (!e && !x) e = 1'b1;
            v.ent = e;
            v.ext = x;
            v.eg  = e && (cnt != CAP);
            v.xg  = x && (cnt != 0);
            v.den = e && (cnt == CAP);
            cnt   = cnt + int'(v.eg) - int'(v.xg);
            v.parked = cnt;
            run_step(v, HMIN + int'($urandom % 4), $sformatf("rnd%0d", k));
            repeat ($urandom % 3) @(negedge clk);
        end

`ifdef SENSOR_DEBOUNCE_EN
        // Short glitch on an open gate must not count; the gate then times out
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        entry_request = 1'b1;
        @(negedge clk);
        entry_request = 1'b0;
        entry_beam    = 1'b1;
        repeat (2) @(negedge clk);
        entry_beam = 1'b0;
        hi = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!entry_gate) break;
            hi++;
        end
        chk("glitch gate_closed", int'(entry_gate), 0);
        chk("glitch parked", int'(parked), 0);
`else
        // A single-sample beam pulse still counts as a pass
        if (model_parked == CAP) run_step(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, CAP - 1), 2, "prep");
        run_step(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, model_parked + 1), 1, "short_beam");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
